// File: rtl/rho_inv_serial.sv
// rho_inv_serial
//   Column-serial inverse of the SWAN64 rho mixing layer (decryption path).
//   rho is an involution, so this computes the same map as the forward layer:
//   T = c0^c1^c2^c3, y column k = ck ^ T.
//   A half-block is accepted in IDLE. Its four columns are folded into T
//   one per clock in ACC. The result is then held in OUT until it is consumed.
// Ports
//   clk, rst           rising-edge clock, synchronous active-high reset
//   in_valid/in_ready  input handshake, x_in [0:SIDE_SIZE-1] (bit 0 = MSB)
//   out_valid/out_ready output handshake, y_out [0:SIDE_SIZE-1]
//   busy               high while a block is in ACC or OUT

// One column lane: unmix a column with the folded parity word.
module rho_col_mix #(
  parameter int W = 8
) (
  input  logic [W-1:0] c,
  input  logic [W-1:0] t,
  output logic [W-1:0] y
);
  assign y = c ^ t;
endmodule

module rho_inv_serial #(
  parameter int BLOCK_SIZE  = 64,
  parameter int SIDE_SIZE   = BLOCK_SIZE / 2,
  parameter int COLUMN_SIZE = SIDE_SIZE / 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [0:SIDE_SIZE-1] x_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [0:SIDE_SIZE-1] y_out,
  output logic                 busy
);
  localparam int NUM_COLS = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  logic [1:0]                              state;
  logic [0:SIDE_SIZE-1]                    x_reg;
  logic [0:SIDE_SIZE-1]                    y_reg;
  logic [COLUMN_SIZE-1:0]                  t_reg;
  logic [1:0]                              col_idx;

  logic [NUM_COLS-1:0][COLUMN_SIZE-1:0]    cols;
  logic [NUM_COLS-1:0][COLUMN_SIZE-1:0]    y_cols;
  logic [0:SIDE_SIZE-1]                    y_nxt;
  logic [COLUMN_SIZE-1:0]                  col_sel;
  logic [COLUMN_SIZE-1:0]                  t_fin;

  // Column k sits at bits [k*COLUMN_SIZE +: COLUMN_SIZE] of the ascending
  // vector, so column 0 is the most significant column.
  for (genvar k = 0; k < NUM_COLS; k++) begin : g_col
    assign cols[k] = x_reg[k*COLUMN_SIZE +: COLUMN_SIZE];
    rho_col_mix #(.W(COLUMN_SIZE)) u_mix (
      .c (cols[k]),
      .t (t_fin),
      .y (y_cols[k])
    );
    assign y_nxt[k*COLUMN_SIZE +: COLUMN_SIZE] = y_cols[k];
  end

  assign col_sel = cols[col_idx];
  // Last ACC step: fold column 3 in on the fly so y_reg loads on the 4th edge.
  assign t_fin   = t_reg ^ cols[NUM_COLS-1];

  // rst gates in_ready so nothing is accepted in the reset cycle.
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == OUT);
  assign busy      = (state == ACC) || (state == OUT);
  assign y_out     = y_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      x_reg   <= '0;
      y_reg   <= '0;
      t_reg   <= '0;
      col_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_reg   <= x_in;
            t_reg   <= '0;
            col_idx <= '0;
            state   <= ACC;
          end
        end
        ACC: begin
          t_reg   <= t_reg ^ col_sel;
          col_idx <= col_idx + 2'd1;
          if (col_idx == 2'd3) begin
            y_reg <= y_nxt;
            state <= OUT;
          end
        end
        OUT: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rho_inv_serial.sv
module tb_rho_inv_serial;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [0:31] x_in;
  logic        out_valid;
  logic        out_ready;
  logic [0:31] y_out;
  logic        busy;

  rho_inv_serial dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y_out     (y_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_acc = 0;
  int prev_acc = -100;
  int hs_cnt = 0;
  int sent   = 0;
  bit chk_space = 0;
  bit keep_valid = 0;
  bit rnd_done = 0;
  logic        prev_ov = 1'b0;
  logic [31:0] prev_y  = '0;
  logic [31:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference rho: split into four byte columns, XOR them all, XOR back.
  function automatic logic [31:0] rho_ref(input logic [31:0] x);
    logic [7:0]  c[4];
    logic [7:0]  t;
    logic [31:0] r;
    t = 8'h00;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      c[k] = x[31-8*k -: 8];
      t = t ^ c[k];
    end
    for (int k = 0; k < 4; k++) r = (r << 8) | {24'h0, c[k] ^ t};
    return r;
  endfunction

  // Monitor: samples on the falling edge, i.e. the values the next rising
  // edge will act on.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !prev_ov) chk("latency", cyc - last_acc, 32'd4);
      if (out_valid && prev_ov)  chk("y_stable", y_out, prev_y);
      if (out_valid)             chk("in_ready_in_out", {31'b0, in_ready}, 32'd0);
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_out: got %h expected no output", y_out);
        end else begin
          chk("y_out", y_out, exp_q.pop_front());
        end
      end
    end
    prev_ov <= rst ? 1'b0 : out_valid;
    prev_y  <= y_out;
  end

  task automatic send(input logic [31:0] x, input logic [31:0] exp);
    int n;
    bit ok;
    in_valid = 1'b1;
    x_in = x;
    n = 0;
    ok = 0;
    while (n < 300) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
      n++;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL accept_timeout: got no in_ready expected accept of %h", x);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(exp);
    sent++;
    if (chk_space) chk("accept_spacing", cyc + 1 - prev_acc, 32'd6);
    prev_acc = cyc + 1;
    last_acc = cyc + 1;
    @(posedge clk); #1;
    if (!keep_valid) in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue", exp_q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    int hs0;
    logic [31:0] x;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x_in = '0;
    @(negedge clk);
    chk("in_ready_during_rst", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy",      {31'b0, busy},      32'd0);
    chk("rst_y_out",     y_out,              32'd0);
    @(posedge clk); #1;

    // Basic, involution and fixed vectors
    out_ready = 1'b1;
    send(32'h01020408, 32'h0E0D0B07); drain();
    send(32'h0E0D0B07, 32'h01020408); drain();
    send(32'h12345678, 32'h1A3C5E70); drain();
    send(32'hFF000000, 32'h00FFFFFF); drain();
    send(32'hAAAAAAAA, 32'hAAAAAAAA); drain();
    send(32'h00000000, 32'h00000000); drain();

    // Backpressure: hold OUT for 10 clocks while offering a new input
    out_ready = 1'b0;
    send(32'h12345678, 32'h1A3C5E70);
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
    @(posedge clk); #1;
    hs0 = hs_cnt;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; x_in = $urandom;
      @(negedge clk);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_y_out", y_out, 32'h1A3C5E70);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_one_handshake", hs_cnt - hs0, 32'd1);
    chk("bp_idle_in_ready", {31'b0, in_ready}, 32'd1);
    chk("bp_idle_out_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;

    // Reset on the 2nd ACC clock discards the block
    send(32'hDEADBEEF, rho_ref(32'hDEADBEEF));
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_y_out",     y_out,              32'd0);
    chk("mid_rst_busy",      {31'b0, busy},      32'd0);
    chk("mid_rst_in_ready2", {31'b0, in_ready},  32'd1);
    @(posedge clk); #1;
    send(32'h12345678, 32'h1A3C5E70); drain();

    // Streaming: back-to-back with in_valid and out_ready held high
    keep_valid = 1; chk_space = 0;
    for (int i = 0; i < 100; i++) begin
      x = $urandom;
      send(x, rho_ref(x));
      chk_space = 1;
    end
    keep_valid = 0; chk_space = 0;
    in_valid = 1'b0;
    drain();

    // Random in_valid gaps and out_ready stalls
    hs0 = hs_cnt;
    n = sent;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          int gap;
          gap = $urandom_range(0, 3);
          for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
          x = $urandom;
          send(x, rho_ref(x));
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    drain();
    chk("rnd_no_drops", hs_cnt - hs0, sent - n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
